// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment encoder/decoder pair: active-low glyph
// table and the dwell FSM state encoding.
package seg7_pkg;

  // Active-low segment patterns, bit0 = a ... bit6 = g, indexed by hex nibble.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } dwell_state_e;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display-bus and decoded-result signals of the scan decoder. The master drives
// the display lines; the slave is the decoder.
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              i_Seg;
  logic [NUM_DIGITS-1:0]   i_Dig_n;
  logic [4*NUM_DIGITS-1:0] o_Value;
  logic [NUM_DIGITS-1:0]   o_Err_Mask;
  logic                    o_Valid;
  logic                    o_Timeout;

  modport master (
    output i_Seg, i_Dig_n,
    input  o_Value, o_Err_Mask, o_Valid, o_Timeout
  );

  modport slave (
    input  i_Seg, i_Dig_n,
    output o_Value, o_Err_Mask, o_Valid, o_Timeout
  );
endinterface

// File: rtl/seg7_to_nibble.sv
// Combinational reverse lookup of an active-low 7-segment pattern to a nibble;
// unrecognised patterns yield nibble 0 with o_Invalid set.
module seg7_to_nibble
  import seg7_pkg::*;
(
  input  logic [6:0] i_Pat,
  output logic [3:0] o_Nibble,
  output logic       o_Invalid
);

  always_comb begin
    // NOTE: defaults assigned first so every path drives both outputs (no latch).
    o_Nibble  = '0;
    o_Invalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i_Pat == SEG_HEX[i]) begin
        o_Nibble  = 4'(i);
        o_Invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the multiplexed 7-segment bus: synchronizes the pins, accepts
// each digit after a stable dwell, and assembles complete frames with a timeout.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  seg7_scan_decoder_if.slave  bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SMP_W = NUM_DIGITS + 7;

  logic [6:0]              r_seg_s1, r_seg_s2;
  logic [NUM_DIGITS-1:0]   r_dig_s1, r_dig_s2;
  logic [SMP_W-1:0]        r_prev_sample;
  dwell_state_e            r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [4*NUM_DIGITS-1:0] r_slots;
  logic [NUM_DIGITS-1:0]   r_slot_err;
  logic [NUM_DIGITS-1:0]   r_captured;
  logic [TO_W-1:0]         r_tcnt;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_err_mask;
  logic                    r_valid;
  logic                    r_timeout;

  logic [NUM_DIGITS-1:0]   w_sel;
  logic                    w_sel_ok;
  logic [SMP_W-1:0]        w_sample;
  logic                    w_same;
  logic                    w_capture;
  logic [3:0]              w_nibble;
  logic                    w_invalid;
  logic [NUM_DIGITS-1:0]   w_cap_mask;
  logic [NUM_DIGITS-1:0]   w_captured_next;
  logic                    w_frame_done;
  logic [4*NUM_DIGITS-1:0] w_value_next;
  logic [NUM_DIGITS-1:0]   w_err_next;

  // Blank/no-digit (all ones) is the idle level of an active-low display.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_dig_s1 <= '1;
      r_dig_s2 <= '1;
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value.
      r_seg_s1 <= bus.i_Seg;
      r_seg_s2 <= r_seg_s1;
      r_dig_s1 <= bus.i_Dig_n;
      r_dig_s2 <= r_dig_s1;
    end
  end

  assign w_sel    = ~r_dig_s2;
  assign w_sel_ok = (w_sel != '0) && ((w_sel & (w_sel - 1'b1)) == '0);
  assign w_sample = {r_dig_s2, r_seg_s2};
  assign w_same   = (w_sample == r_prev_sample);

  seg7_to_nibble u_to_nibble (
    .i_Pat     (r_seg_s2),
    .o_Nibble  (w_nibble),
    .o_Invalid (w_invalid)
  );

  // The edge on which the count would reach STABLE_CYCLES is the capture edge.
  assign w_capture = (r_state == TRACK) && w_sel_ok && w_same &&
                     (r_cnt == CNT_W'(STABLE_CYCLES - 1));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_prev_sample <= '1;
    end else begin
      r_prev_sample <= w_sample;
      if (!w_sel_ok) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= TRACK;
            r_cnt   <= CNT_W'(1);
          end
          TRACK: begin
            if (!w_same) begin
              r_cnt <= CNT_W'(1);
            end else if (w_capture) begin
              r_state <= HELD;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          HELD: begin
            if (!w_same) begin
              r_state <= TRACK;
              r_cnt   <= CNT_W'(1);
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // sel is one-hot whenever a capture fires, so it doubles as the slot mask.
  assign w_cap_mask      = w_capture ? w_sel : '0;
  assign w_captured_next = r_captured | w_cap_mask;
  assign w_frame_done    = w_capture && (&w_captured_next);

  always_comb begin
    w_value_next = r_slots;
    w_err_next   = r_slot_err;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_cap_mask[i]) begin
        w_value_next[4*i +: 4] = w_nibble;
        w_err_next[i]          = w_invalid;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      // NOTE: slot storage is reset too, so no pre-reset digit can ever surface.
      r_slots    <= '0;
      r_slot_err <= '0;
    end else if (w_capture) begin
      r_slots    <= w_value_next;
      r_slot_err <= w_err_next;
    end
  end

  // A capture on the timeout edge takes priority and restarts the timeout.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_captured <= '0;
      r_tcnt     <= '0;
      r_value    <= '0;
      r_err_mask <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      if (w_capture) begin
        r_tcnt <= '0;
        if (w_frame_done) begin
          r_captured <= '0;
          r_value    <= w_value_next;
          r_err_mask <= w_err_next;
          r_valid    <= 1'b1;
        end else begin
          r_captured <= w_captured_next;
        end
      end else if (r_captured != '0) begin
        if (r_tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          r_captured <= '0;
          r_tcnt     <= '0;
          r_timeout  <= 1'b1;
        end else begin
          r_tcnt <= r_tcnt + 1'b1;
        end
      end else begin
        r_tcnt <= '0;
      end
    end
  end

  assign bus.o_Value    = r_value;
  assign bus.o_Err_Mask = r_err_mask;
  assign bus.o_Valid    = r_valid;
  assign bus.o_Timeout  = r_timeout;

endmodule
